// File: rtl/mips_rf_pkg.sv
// Shared register-file constants and the write-command record used by the
// writeback arbiter and its one-hot decoder.
package mips_rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  en;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } rf_wr_cmd_t;

endpackage

// File: rtl/rf_onehot_decoder.sv
// 5-to-32 register select decoder: output bit k is set when sel == k.
module rf_onehot_decoder
   import mips_rf_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] sel,
   output logic [NUM_REGS-1:0]   onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
         assign onehot[gi] = (sel == REG_ADDR_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; grants one
// writeback source per cycle and issues a registered write command.
module rf_write_arbiter
   import mips_rf_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int CNT_W = 16
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*REG_ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0]     req_data,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        rf_stall,
   output logic                        wr_en,
   output logic [REG_ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]           wr_data,
   output logic [NUM_REGS-1:0]         wr_onehot,
   output logic [$clog2(N_REQ)-1:0]    grant_id,
   output logic [CNT_W-1:0]            contention_cnt
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int SW   = ID_W + 1;

   logic [REG_ADDR_W-1:0] addr_arr [N_REQ];
   logic [DATA_W-1:0]     data_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;
   rf_wr_cmd_t            cmd_reg, cmd_next;
   logic [NUM_REGS-1:0]   onehot_reg, onehot_next;
   logic [ID_W-1:0]       grant_id_reg, grant_id_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;

   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_idx;
   logic [SW-1:0]         scan_sum;
   logic [SW-1:0]         ptr_sum;
   logic [N_REQ-1:0]      ready;
   logic [REG_ADDR_W-1:0] sel_addr;
   logic [NUM_REGS-1:0]   sel_onehot;

   // Scan from rr_ptr with wrap; reset and stall both suppress every grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_sum  = '0;
      ready     = '0;
      if (!reset && !rf_stall) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + SW'(k);
            if (scan_sum >= SW'(N_REQ))
               scan_sum = scan_sum - SW'(N_REQ);
            if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
               gnt_found = 1'b1;
               gnt_idx   = scan_sum[ID_W-1:0];
            end
         end
      end
      if (gnt_found)
         ready[gnt_idx] = 1'b1;
   end

   assign sel_addr = addr_arr[gnt_idx];

   rf_onehot_decoder u_dec (
      .sel    (sel_addr),
      .onehot (sel_onehot)
   );

   always_comb begin
      cmd_next      = cmd_reg;
      cmd_next.en   = 1'b0;
      onehot_next   = '0;
      grant_id_next = grant_id_reg;
      rr_ptr_next   = rr_ptr_reg;
      cnt_next      = cnt_reg;
      ptr_sum       = {1'b0, gnt_idx} + SW'(1);
      if (gnt_found) begin
         // Writes to $0 are consumed but never reach the register file.
         cmd_next.addr = sel_addr;
         cmd_next.data = data_arr[gnt_idx];
         cmd_next.en   = (sel_addr != REG_ZERO);
         onehot_next   = (sel_addr != REG_ZERO) ? sel_onehot : '0;
         grant_id_next = gnt_idx;
         rr_ptr_next   = (ptr_sum >= SW'(N_REQ)) ? '0 : ptr_sum[ID_W-1:0];
      end
      if ((|(req_valid & ~ready)) && (cnt_reg != '1))
         cnt_next = cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_reg   <= '0;
         cmd_reg      <= '0;
         onehot_reg   <= '0;
         grant_id_reg <= '0;
         cnt_reg      <= '0;
      end else begin
         rr_ptr_reg   <= rr_ptr_next;
         cmd_reg      <= cmd_next;
         onehot_reg   <= onehot_next;
         grant_id_reg <= grant_id_next;
         cnt_reg      <= cnt_next;
      end
   end

   assign req_ready      = ready;
   assign wr_en          = cmd_reg.en;
   assign wr_addr        = cmd_reg.addr;
   assign wr_data        = cmd_reg.data;
   assign wr_onehot      = onehot_reg;
   assign grant_id       = grant_id_reg;
   assign contention_cnt = cnt_reg;

endmodule
